// File: rtl/calc_keypad_scan.sv
// Purpose: scan a 4x4 key matrix and emit one calc_top command code per press.
// Latency: a clean press on the driven column reaches cmd_o within 2 + SCAN_DIV + DEBOUNCE*SCAN_DIV + 1 cycles.
// Backpressure: none; cmd_o is a timed pulse that the consumer must take as it comes.
//
// Ports:
//   clock_i      rising-edge clock for all logic
//   reset_ni     asynchronous active-low reset
//   col_drive_o  one-hot, active-high column strobe
//   row_sense_i  raw row lines from the matrix (asynchronous to clock_i)
//   cmd_o        key code 0..14 while cmd_valid_o is high, 4'b1111 otherwise
//   cmd_valid_o  high while cmd_o carries a key code
//   busy_o       high whenever the scanner is not in SCAN
//
// Build option: define CALC_KEY_REPEAT_EN to re-emit a held key every
// HOLD_CYCLES + REPEAT_CYCLES cycles. Without it, REPEAT_CYCLES and its
// counter do not exist and each press yields exactly one code.
//
// Parameter limits: SCAN_DIV >= 3 (the synchronizer must settle inside a
// column slot), DEBOUNCE >= 1, HOLD_CYCLES >= 1, GAP_CYCLES >= 1.

module calc_keypad_scan #(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE      = 3,
    parameter int HOLD_CYCLES   = 10,
    parameter int GAP_CYCLES    = 4
`ifdef CALC_KEY_REPEAT_EN
   ,parameter int REPEAT_CYCLES = 64
`endif
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    output logic [3:0] col_drive_o,
    input  logic [3:0] row_sense_i,
    output logic [3:0] cmd_o,
    output logic       cmd_valid_o,
    output logic       busy_o
);

    localparam logic [3:0] CMD_IDLE = 4'b1111;
    localparam logic [3:0] KEY_NONE = 4'd15;

    localparam int DIV_W  = $clog2(SCAN_DIV + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

`ifdef CALC_KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HOLD     = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]        sync1_q;
    logic [3:0]        sync2_q;
    logic [DIV_W-1:0]  div_q;
    logic [3:0]        col_drive_q;
    state_e            state_q;
    logic [3:0]        key_q;       // latched key index
    logic [3:0]        pat_q;       // latched row pattern
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  rel_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [3:0]        cmd_q;
    logic              cmd_valid_q;
    logic              busy_q;
`ifdef CALC_KEY_REPEAT_EN
    logic [RPT_W-1:0]  rpt_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    logic       sample_en;
    logic       row_single;
    logic       key_ok;
    logic       row_clear;
    logic       row_match;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic [3:0] key_idx;
    logic [3:0] col_next;

    // Two-flop synchronizer on the raw row lines.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= row_sense_i;
            sync2_q <= sync1_q;
        end
    end

    // Rows are only trusted on the last cycle of a column slot, by which
    // point the synchronizer holds rows belonging to the current column.
    assign sample_en  = (div_q == DIV_LAST);
    assign row_single = $onehot(sync2_q);
    assign row_clear  = (sync2_q == 4'b0000);
    assign row_match  = (sync2_q == pat_q);
    assign col_next   = {col_drive_q[2:0], col_drive_q[3]};

    always_comb begin
        row_idx = 2'd0;
        case (sync2_q)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        case (col_drive_q)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    assign key_idx = {row_idx, col_idx};
    // Index 15 has no command meaning and is treated exactly like no key.
    assign key_ok  = row_single && (key_idx != KEY_NONE);

    // ------------------------------------------------------------------
    // Scan / debounce / emit state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_SCAN;
            div_q       <= '0;
            col_drive_q <= 4'b0001;
            key_q       <= '0;
            pat_q       <= '0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            cmd_q       <= CMD_IDLE;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CALC_KEY_REPEAT_EN
            rpt_cnt_q   <= '0;
`endif
        end else begin
            // Slot timer runs in every state so DEBOUNCE and RELEASE keep
            // sampling at the same cadence as SCAN.
            if (sample_en) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            case (state_q)
                ST_SCAN: begin
                    if (sample_en) begin
                        if (key_ok) begin
                            key_q     <= key_idx;
                            pat_q     <= sync2_q;
                            deb_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_DEBOUNCE;
                        end else begin
                            col_drive_q <= col_next;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (sample_en) begin
                        if (row_match) begin
                            if (deb_cnt_q == DEB_LAST) begin
                                cmd_q       <= key_q;
                                cmd_valid_q <= 1'b1;
                                hold_cnt_q  <= '0;
                                state_q     <= ST_HOLD;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + 1'b1;
                            end
                        end else begin
                            // A bounce abandons this key and moves on, so a
                            // chattering key cannot starve the other columns.
                            col_drive_q <= col_next;
                            busy_q      <= 1'b0;
                            state_q     <= ST_SCAN;
                        end
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        cmd_q       <= CMD_IDLE;
                        cmd_valid_q <= 1'b0;
                        rel_cnt_q   <= '0;
`ifdef CALC_KEY_REPEAT_EN
                        rpt_cnt_q   <= '0;
`endif
                        state_q     <= ST_RELEASE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (sample_en) begin
                        if (row_clear) begin
                            if (rel_cnt_q == DEB_LAST) begin
                                gap_cnt_q <= '0;
                                state_q   <= ST_GAP;
                            end else begin
                                rel_cnt_q <= rel_cnt_q + 1'b1;
                            end
                        end else begin
                            rel_cnt_q <= '0;
                        end
                    end
`ifdef CALC_KEY_REPEAT_EN
                    // Any sample that differs from the held key restarts the
                    // repeat interval; a clear sample here also cannot fire a
                    // repeat, so the GAP transition above never collides.
                    if (sample_en && !row_match) begin
                        rpt_cnt_q <= '0;
                    end else if (rpt_cnt_q == RPT_LAST) begin
                        rpt_cnt_q   <= '0;
                        cmd_q       <= key_q;
                        cmd_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= ST_HOLD;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 1'b1;
                    end
`endif
                end

                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        // Restart the slot so the new column gets a full
                        // settle time before its first sample.
                        div_q       <= '0;
                        col_drive_q <= col_next;
                        busy_q      <= 1'b0;
                        state_q     <= ST_SCAN;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    cmd_q       <= CMD_IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    col_drive_q <= 4'b0001;
                    state_q     <= ST_SCAN;
                end
            endcase
        end
    end

    assign col_drive_o = col_drive_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign busy_o      = busy_q;

endmodule
